// File: rtl/jpeg_idct_transpose_ctrl.sv
// jpeg_idct_transpose_ctrl
// Transpose buffer control between the IDCT row and column passes. Incoming
// 4x4 tiles are written row-major into one half of an external dual-port
// 32x32 RAM and read back column-major into a 2-entry output FIFO. The two
// RAM halves ping-pong so one tile can fill while the other drains.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   inport_*              write-side stream (valid/data/accept)
//   outport_*             transposed stream (valid/data/last/accept)
//   ram_addr0_o/data0_o/wr0_o  RAM port 0, write only
//   ram_addr1_o/data1_i   RAM port 1, read only, data one cycle after address
module jpeg_idct_transpose_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_valid_i,
    input  logic [31:0] inport_data_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    output logic [4:0]  ram_addr0_o,
    output logic [31:0] ram_data0_o,
    output logic        ram_wr0_o,
    output logic [4:0]  ram_addr1_o,
    input  logic [31:0] ram_data1_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    // Tile tracking state
    logic              wr_bank_q,  wr_bank_d;
    logic              rd_bank_q,  rd_bank_d;
    logic [1:0]        full_q,     full_d;
    logic [IDX_W-1:0]  wr_idx_q,   wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q,   rd_idx_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    // Output FIFO state
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];

    logic wr_fire;
    logic rd_fire;
    logic fifo_empty;
    logic out_pop;
    logic fifo_push;
    logic fifo_pop;

    // Write side: a bank accepts words until its tile is complete
    assign inport_accept_o = ~full_q[wr_bank_q];
    assign wr_fire         = inport_valid_i & inport_accept_o;
    assign ram_wr0_o       = wr_fire;
    assign ram_addr0_o     = {wr_bank_q, wr_idx_q};
    assign ram_data0_o     = inport_data_i;

    // Read side: column-major address; reserve a FIFO slot for every word in flight
    assign ram_addr1_o = {rd_bank_q, rd_idx_q[1:0], rd_idx_q[3:2]};
    assign rd_fire     = full_q[rd_bank_q]
                       & ((3'(out_count_q) + 3'(inflight_q)) < 3'd2);

    // Empty FIFO lets the returning RAM word fall through to the output
    assign fifo_empty      = (out_count_q == '0);
    assign outport_valid_o = ~fifo_empty | inflight_q;
    assign outport_data_o  = fifo_empty ? ram_data1_i     : fifo_data_q[head_q];
    assign outport_last_o  = fifo_empty ? inflight_last_q : fifo_last_q[head_q];
    assign out_pop         = outport_valid_o & outport_accept_i;
    assign fifo_push       = inflight_q & ~(fifo_empty & out_pop);
    assign fifo_pop        = out_pop & ~fifo_empty;

    // Next-state logic
    always_comb begin
        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        full_d          = full_q;
        wr_idx_d        = wr_idx_q;
        rd_idx_d        = rd_idx_q;
        inflight_d      = rd_fire;
        inflight_last_d = rd_fire & (rd_idx_q == IDX_LAST);
        out_count_d     = out_count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Writer only targets a non-full bank and reader a full one, so the
        // set above and the clear below never touch the same bit.
        if (rd_fire) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if (rd_idx_q == IDX_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end

        if (fifo_push) begin
            fifo_data_d[tail_q] = ram_data1_i;
            fifo_last_d[tail_q] = inflight_last_q;
            tail_d              = ~tail_q;
        end

        if (fifo_pop) begin
            head_d = ~head_q;
        end

        case ({fifo_push, fifo_pop})
            2'b10:   out_count_d = out_count_q + CNT_W'(1);
            2'b01:   out_count_d = out_count_q - CNT_W'(1);
            default: out_count_d = out_count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            full_q          <= '0;
            wr_idx_q        <= '0;
            rd_idx_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            out_count_q     <= '0;
            head_q          <= 1'b0;
            tail_q          <= 1'b0;
            fifo_data_q     <= '{default: '0};
            fifo_last_q     <= '{default: 1'b0};
        end else begin
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            full_q          <= full_d;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            out_count_q     <= out_count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
        end
    end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Bench for jpeg_idct_transpose_ctrl: models the external read-first RAM,
// predicts the transposed order of every completed input tile and compares
// it against the output stream.
module tb_jpeg_idct_transpose_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic        outport_last_o;
    logic        outport_accept_i;
    logic [4:0]  ram_addr0_o;
    logic [31:0] ram_data0_o;
    logic        ram_wr0_o;
    logic [4:0]  ram_addr1_o;
    logic [31:0] ram_data1_i;

    always #5 clk_i = ~clk_i;

    jpeg_idct_transpose_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_last_o   (outport_last_o),
        .outport_accept_i (outport_accept_i),
        .ram_addr0_o      (ram_addr0_o),
        .ram_data0_o      (ram_data0_o),
        .ram_wr0_o        (ram_wr0_o),
        .ram_addr1_o      (ram_addr1_o),
        .ram_data1_i      (ram_data1_i)
    );

    // Dual-port RAM, read-first, one-cycle read latency
    logic [31:0] ram_mem [32];
    logic [31:0] ram_rd_q;
    always @(posedge clk_i) begin
        if (ram_wr0_o) ram_mem[ram_addr0_o] <= ram_data0_o;
        ram_rd_q <= ram_mem[ram_addr1_o];
    end
    assign ram_data1_i = ram_rd_q;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_out   = 0;
    int          acc_mode = 0;   // 0 accept high, 1 random, 2 held low
    logic        watch_rise = 1'b0;

    // Monitor-owned state
    logic        m_wr_bank;
    logic [3:0]  m_wr_idx;
    logic [31:0] tile_buf [16];
    int          first_out_cyc;
    int          last_wr_cyc;
    int          in_stalls;
    logic        rise_done;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [4:0]  prev_addr1;
    logic        prev_acc;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output-side acceptance driver
    initial begin
        outport_accept_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (acc_mode)
                0:       outport_accept_i = 1'b1;
                1:       outport_accept_i = ($urandom_range(3) != 0);
                default: outport_accept_i = 1'b0;
            endcase
        end
    end

    // Monitor and scoreboard
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            m_wr_bank     = 1'b0;
            m_wr_idx      = 4'd0;
            first_out_cyc = -1;
            last_wr_cyc   = -1;
            in_stalls     = 0;
            rise_done     = 1'b0;
            prev_stall    = 1'b0;
            prev_addr1    = 5'd0;
            prev_acc      = 1'b0;
        end else begin
            if (inport_valid_i && inport_accept_o) begin
                chk("wr_strobe", 32'(ram_wr0_o), 32'd1);
                chk("wr_addr", 32'(ram_addr0_o), 32'({m_wr_bank, m_wr_idx}));
                chk("wr_data", ram_data0_o, inport_data_i);
                tile_buf[m_wr_idx] = inport_data_i;
                if (m_wr_idx == 4'd15) begin
                    for (int j = 0; j < 16; j++) begin
                        exp_t e;
                        e.data = tile_buf[(j % 4) * 4 + j / 4];
                        e.last = (j == 15);
                        exp_q.push_back(e);
                    end
                    last_wr_cyc = cyc;
                    m_wr_bank   = ~m_wr_bank;
                end
                m_wr_idx = m_wr_idx + 4'd1;
            end else begin
                chk("wr_idle", 32'(ram_wr0_o), 32'd0);
                if (inport_valid_i) in_stalls++;
            end

            if (prev_stall) begin
                chk("stall_valid", 32'(outport_valid_o), 32'd1);
                chk("stall_data", outport_data_o, prev_data);
                chk("stall_last", 32'(outport_last_o), 32'(prev_last));
            end

            if (outport_valid_o && outport_accept_i) begin
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", outport_data_o, e.data);
                    chk("out_last", 32'(outport_last_o), 32'(e.last));
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
                n_out++;
            end

            // Bank 1 read address appears the cycle after bank 0's final read
            if (watch_rise && !rise_done && ram_addr1_o == 5'd16 && prev_addr1 != 5'd16) begin
                chk("acc_rise", 32'(inport_accept_o), 32'd1);
                chk("acc_before_rise", 32'(prev_acc), 32'd0);
                rise_done = 1'b1;
            end

            prev_stall = outport_valid_o && !outport_accept_i;
            prev_data  = outport_data_o;
            prev_last  = outport_last_o;
            prev_addr1 = ram_addr1_o;
            prev_acc   = inport_accept_o;
        end
    end

    task automatic do_reset();
        rst_i          = 1'b1;
        inport_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int b = 0;
        inport_valid_i = 1'b1;
        inport_data_i  = d;
        @(negedge clk_i);
        while (!inport_accept_o && b < 2000) begin
            @(negedge clk_i);
            b++;
        end
        if (b >= 2000) chk("send_timeout", 32'(inport_accept_o), 32'd1);
        @(posedge clk_i);
        #1;
        inport_valid_i = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge clk_i);
            b++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int base;
        int b;
        logic [4:0] a_hold;

        inport_data_i = '0;
        do_reset();

        // Reset state
        @(negedge clk_i);
        chk("rst_valid", 32'(outport_valid_o), 32'd0);
        chk("rst_last", 32'(outport_last_o), 32'd0);
        chk("rst_accept", 32'(inport_accept_o), 32'd1);
        chk("rst_wr", 32'(ram_wr0_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Single tile, value = index, latency from final write
        base = n_out;
        for (int i = 0; i < 16; i++) send(32'(i));
        drain();
        chk("t1_outs", 32'(n_out - base), 32'd16);
        chk("t1_latency", 32'(first_out_cyc - last_wr_cyc), 32'd2);

        // Back-to-back three tiles, no input stall expected
        do_reset();
        base = n_out;
        for (int i = 0; i < 48; i++) send(32'h1000 + 32'(i));
        drain();
        chk("b2b_outs", 32'(n_out - base), 32'd48);
        chk("b2b_in_stalls", 32'(in_stalls), 32'd0);

        // Back-pressure mid-tile
        do_reset();
        base = n_out;
        for (int i = 0; i < 16; i++) send(32'h2000 + 32'(i));
        b = 0;
        while ((n_out - base) < 5 && b < 500) begin
            @(negedge clk_i);
            b++;
        end
        chk("bp_started", 32'((n_out - base) >= 5), 32'd1);
        acc_mode = 2;
        repeat (4) @(negedge clk_i);
        a_hold = ram_addr1_o;
        repeat (6) @(negedge clk_i);
        chk("bp_reads_halted", 32'(ram_addr1_o), 32'(a_hold));
        acc_mode = 0;
        drain();
        chk("bp_outs", 32'(n_out - base), 32'd16);

        // Both banks full while downstream blocks
        do_reset();
        acc_mode = 2;
        @(posedge clk_i);
        #1;
        base = n_out;
        for (int i = 0; i < 32; i++) send(32'h4000 + 32'(i));
        @(negedge clk_i);
        chk("full_accept_low", 32'(inport_accept_o), 32'd0);
        repeat (5) @(negedge clk_i);
        chk("full_accept_still_low", 32'(inport_accept_o), 32'd0);
        watch_rise = 1'b1;
        acc_mode   = 0;
        drain();
        chk("full_rise_seen", 32'(rise_done), 32'd1);
        chk("full_outs", 32'(n_out - base), 32'd32);
        watch_rise = 1'b0;

        // Reset mid-tile discards the partial tile
        do_reset();
        for (int i = 0; i < 7; i++) send(32'hDEAD0000 + 32'(i));
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("rst_no_out", 32'(outport_valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        base = n_out;
        for (int i = 0; i < 16; i++) send(32'h3000 + 32'(i));
        drain();
        chk("rst_outs", 32'(n_out - base), 32'd16);

        // Random valid/accept over 1000 tiles
        do_reset();
        acc_mode = 1;
        base = n_out;
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(3) == 0) begin
                    repeat ($urandom_range(3, 1)) @(posedge clk_i);
                    #1;
                end
                send($urandom);
            end
        end
        drain();
        acc_mode = 0;
        chk("rand_outs", 32'(n_out - base), 32'd16000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
